// File: rtl/survivor_traceback_if.sv
// Decision-vector input and decoded-bit output of the Viterbi traceback unit.
// master = add-compare-select side / bit consumer, slave = traceback unit.
interface survivor_traceback_if #(
  parameter int NUM_STATES = 4
) ();
  localparam int STATE_W = $clog2(NUM_STATES);

  logic                  dec_valid;
  logic                  dec_ready;
  logic [NUM_STATES-1:0] dec_bits;
  logic [STATE_W-1:0]    best_state;
  logic                  flush;
  logic                  out_valid;
  logic                  out_bit;
  logic                  out_last;

  modport master (
    output dec_valid, dec_bits, best_state, flush,
    input  dec_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  dec_valid, dec_bits, best_state, flush,
    output dec_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/survivor_traceback.sv
// Viterbi survivor-path traceback: circular decision memory, one backward step
// per clock over a TB_DEPTH window, one decoded bit per window, drain on flush.
module survivor_traceback #(
  parameter int NUM_STATES = 4,
  parameter int TB_DEPTH   = 8
) (
  input  logic clk,
  input  logic rst_n,
  survivor_traceback_if.slave bus
);
  localparam int STATE_W = $clog2(NUM_STATES);
  localparam int PTR_W   = $clog2(TB_DEPTH);
  localparam int CNT_W   = $clog2(TB_DEPTH + 1);

  typedef enum logic [1:0] {FILL, TRACE, OUT} state_t;

  state_t              state_reg,    state_next;
  logic [CNT_W-1:0]    count_reg,    count_next;
  logic [PTR_W-1:0]    wr_ptr_reg,   wr_ptr_next;
  logic [STATE_W-1:0]  tb_start_reg, tb_start_next;
  logic [STATE_W-1:0]  s_reg,        s_next;
  logic [PTR_W-1:0]    ptr_reg,      ptr_next;
  logic [CNT_W-1:0]    steps_reg,    steps_next;
  logic                drain_reg,    drain_next;
  logic                out_bit_reg,  out_bit_next;

  logic [NUM_STATES-1:0] mem [TB_DEPTH];

  logic                  accept;
  logic [CNT_W-1:0]      count_after;
  logic [PTR_W-1:0]      wr_ptr_inc;
  logic [PTR_W-1:0]      newest_ptr;
  logic [PTR_W-1:0]      ptr_dec;
  logic [NUM_STATES-1:0] read_bits;
  logic [STATE_W-1:0]    pred_s;

  assign accept      = (state_reg == FILL) && bus.dec_valid;
  assign count_after = count_reg + CNT_W'(accept);
  assign wr_ptr_inc  = (wr_ptr_reg == PTR_W'(TB_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
  assign newest_ptr  = (wr_ptr_reg == '0) ? PTR_W'(TB_DEPTH - 1) : wr_ptr_reg - PTR_W'(1);
  assign ptr_dec     = (ptr_reg == '0) ? PTR_W'(TB_DEPTH - 1) : ptr_reg - PTR_W'(1);

  // Predecessor: shift the state left and append this step's decision bit.
  assign read_bits = mem[ptr_reg];
  assign pred_s    = STATE_W'({s_reg, read_bits[s_reg]});

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= bus.dec_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      tb_start_reg <= '0;
      s_reg        <= '0;
      ptr_reg      <= '0;
      steps_reg    <= '0;
      drain_reg    <= 1'b0;
      out_bit_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      tb_start_reg <= tb_start_next;
      s_reg        <= s_next;
      ptr_reg      <= ptr_next;
      steps_reg    <= steps_next;
      drain_reg    <= drain_next;
      out_bit_reg  <= out_bit_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    tb_start_next = tb_start_reg;
    s_next        = s_reg;
    ptr_next      = ptr_reg;
    steps_next    = steps_reg;
    drain_next    = drain_reg;
    out_bit_next  = out_bit_reg;

    bus.dec_ready = (state_reg == FILL);
    bus.out_valid = (state_reg == OUT);
    bus.out_bit   = (state_reg == OUT) ? s_reg[STATE_W-1] : out_bit_reg;
    bus.out_last  = (state_reg == OUT) && drain_reg && (count_reg == CNT_W'(1));

    case (state_reg)
      FILL: begin
        if (accept) begin
          wr_ptr_next   = wr_ptr_inc;
          count_next    = count_after;
          tb_start_next = bus.best_state;
        end
        if (accept && (count_after == CNT_W'(TB_DEPTH))) begin
          state_next = TRACE;
          s_next     = bus.best_state;
          ptr_next   = wr_ptr_reg;
          steps_next = CNT_W'(TB_DEPTH - 1);
        end else if (bus.flush && (count_after != '0)) begin
          // A beat on the flush edge is the newest entry and sets the start state.
          drain_next = 1'b1;
          s_next     = accept ? bus.best_state : tb_start_reg;
          ptr_next   = accept ? wr_ptr_reg : newest_ptr;
          steps_next = count_after - CNT_W'(1);
          state_next = (count_after == CNT_W'(1)) ? OUT : TRACE;
        end
      end
      TRACE: begin
        s_next     = pred_s;
        ptr_next   = ptr_dec;
        steps_next = steps_reg - CNT_W'(1);
        if (steps_reg == CNT_W'(1)) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_bit_next = s_reg[STATE_W-1];
        count_next   = count_reg - CNT_W'(1);
        if (drain_reg && (count_reg > CNT_W'(1))) begin
          s_next     = tb_start_reg;
          ptr_next   = newest_ptr;
          steps_next = count_reg - CNT_W'(2);
          state_next = (count_reg == CNT_W'(2)) ? OUT : TRACE;
        end else begin
          drain_next = 1'b0;
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end
endmodule
